// File: rtl/ps2_pkg.sv
// Shared constants and state encodings for the PS/2 Set-2 key event parser.
//   PS2_EXT / PS2_BRK : E0 extended prefix, F0 break prefix
//   PS2_BAT / PS2_ACK : keyboard status bytes swallowed while idle
//   pop_state_e       : FIFO pop handshake (fetch a byte, then guard)
//   parse_state_e     : prefix tracking between scan-code bytes
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam logic [7:0] PS2_BAT = 8'hAA;
  localparam logic [7:0] PS2_ACK = 8'hFA;

  typedef enum logic {
    StFetch,
    StGuard
  } pop_state_e;

  typedef enum logic [1:0] {
    StIdle,
    StExt,
    StBrk,
    StExtBrk
  } parse_state_e;

endpackage

// File: rtl/ps2_scan2ascii.sv
// Combinational Set-2 scan code to lowercase ASCII lookup.
//   i_code  : 8-bit Set-2 make code (prefixes already stripped)
//   o_ascii : lowercase letter, digit, space (20) or CR (0D); 8'h00 if unmapped
module ps2_scan2ascii (
  input  logic [7:0] i_code,
  output logic [7:0] o_ascii
);

  always_comb begin
    o_ascii = 8'h00;
    case (i_code)
      8'h1C: o_ascii = 8'h61; // a
      8'h32: o_ascii = 8'h62;
      8'h21: o_ascii = 8'h63;
      8'h23: o_ascii = 8'h64;
      8'h24: o_ascii = 8'h65;
      8'h2B: o_ascii = 8'h66;
      8'h34: o_ascii = 8'h67;
      8'h33: o_ascii = 8'h68;
      8'h43: o_ascii = 8'h69;
      8'h3B: o_ascii = 8'h6A;
      8'h42: o_ascii = 8'h6B;
      8'h4B: o_ascii = 8'h6C;
      8'h3A: o_ascii = 8'h6D;
      8'h31: o_ascii = 8'h6E;
      8'h44: o_ascii = 8'h6F;
      8'h4D: o_ascii = 8'h70;
      8'h15: o_ascii = 8'h71;
      8'h2D: o_ascii = 8'h72;
      8'h1B: o_ascii = 8'h73;
      8'h2C: o_ascii = 8'h74;
      8'h3C: o_ascii = 8'h75;
      8'h2A: o_ascii = 8'h76;
      8'h1D: o_ascii = 8'h77;
      8'h22: o_ascii = 8'h78;
      8'h35: o_ascii = 8'h79;
      8'h1A: o_ascii = 8'h7A; // z
      8'h45: o_ascii = 8'h30; // 0
      8'h16: o_ascii = 8'h31;
      8'h1E: o_ascii = 8'h32;
      8'h26: o_ascii = 8'h33;
      8'h25: o_ascii = 8'h34;
      8'h2E: o_ascii = 8'h35;
      8'h36: o_ascii = 8'h36;
      8'h3D: o_ascii = 8'h37;
      8'h3E: o_ascii = 8'h38;
      8'h46: o_ascii = 8'h39; // 9
      8'h29: o_ascii = 8'h20; // space
      8'h5A: o_ascii = 8'h0D; // enter
      default: o_ascii = 8'h00;
    endcase
  end

endmodule

// File: rtl/ps2_key_event.sv
// Pops raw scan-code bytes from the ps2_keyboard FIFO and turns Set-2 sequences
// (make, F0 break, E0 extended, E0 F0) into single key events.
//   clock, reset          : single clock, synchronous active-high reset
//   kbd_ready/kbd_data    : FIFO non-empty flag and head byte
//   kbd_overflow          : FIFO overflow indication (latched into err_overflow)
//   kbd_nextdata_n        : active-low one-cycle pop strobe
//   ev_*                  : event fields, ev_valid pulses, fields hold until next event
//   key_down/held_code    : currently held key, {ext,code}
//   press_count           : counted make events, wraps modulo 2^CNT_W
//   err_overflow          : sticky overflow flag
module ps2_key_event
  import ps2_pkg::*;
#(
  parameter int unsigned CNT_W        = 8,
  parameter bit          COUNT_REPEAT = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             kbd_ready,
  input  logic [7:0]       kbd_data,
  input  logic             kbd_overflow,
  output logic             kbd_nextdata_n,
  output logic             ev_valid,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_release,
  output logic             ev_repeat,
  output logic [7:0]       ev_ascii,
  output logic             key_down,
  output logic [8:0]       held_code,
  output logic [CNT_W-1:0] press_count,
  output logic             err_overflow
);

  // ---------------- FIFO pop handshake ----------------
  pop_state_e r_pop_state, w_pop_state_d;
  logic       r_pop_n, w_pop_n_d;
  logic       w_take;
  logic [7:0] r_byte;
  logic       r_byte_vld;

  // GUARD lasts two cycles: one with the strobe low, one with it high again, so the
  // keyboard FIFO has updated kbd_ready before it is sampled next.
  always_comb begin
    w_pop_state_d = r_pop_state;
    w_pop_n_d     = 1'b1;
    w_take        = 1'b0;
    unique case (r_pop_state)
      StFetch: begin
        if (kbd_ready) begin
          w_take        = 1'b1;
          w_pop_n_d     = 1'b0;
          w_pop_state_d = StGuard;
        end
      end
      StGuard: begin
        if (r_pop_n) w_pop_state_d = StFetch;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pop_state <= StFetch;
      r_pop_n     <= 1'b1;
      r_byte_vld  <= 1'b0;
      r_byte      <= 8'h00;
    end else begin
      r_pop_state <= w_pop_state_d;
      r_pop_n     <= w_pop_n_d;
      r_byte_vld  <= w_take;
      if (w_take) r_byte <= kbd_data;
    end
  end

  // ---------------- Prefix parser ----------------
  parse_state_e r_parse, w_parse_d;
  logic         w_emit, w_ext, w_rel;

  always_comb begin
    w_parse_d = r_parse;
    w_emit    = 1'b0;
    w_ext     = 1'b0;
    w_rel     = 1'b0;
    if (r_byte_vld) begin
      unique case (r_parse)
        StIdle: begin
          if (r_byte == PS2_EXT)      w_parse_d = StExt;
          else if (r_byte == PS2_BRK) w_parse_d = StBrk;
          else if (r_byte != PS2_BAT && r_byte != PS2_ACK) w_emit = 1'b1;
        end
        StExt: begin
          if (r_byte == PS2_BRK)      w_parse_d = StExtBrk;
          else if (r_byte != PS2_EXT) begin
            w_emit    = 1'b1;
            w_ext     = 1'b1;
            w_parse_d = StIdle;
          end
        end
        StBrk: begin
          // E0 after F0 is malformed; restart as an extended sequence.
          if (r_byte == PS2_EXT)      w_parse_d = StExt;
          else if (r_byte != PS2_BRK) begin
            w_emit    = 1'b1;
            w_rel     = 1'b1;
            w_parse_d = StIdle;
          end
        end
        StExtBrk: begin
          if (r_byte != PS2_EXT && r_byte != PS2_BRK) begin
            w_emit    = 1'b1;
            w_ext     = 1'b1;
            w_rel     = 1'b1;
            w_parse_d = StIdle;
          end
        end
      endcase
    end
  end

  // ---------------- Event / held-key state ----------------
  logic [7:0]       w_ascii;
  logic [8:0]       w_key;
  logic             w_match;
  logic             r_ev_valid, r_ev_ext, r_ev_release, r_ev_repeat, r_key_down, r_err;
  logic [7:0]       r_ev_code, r_ev_ascii;
  logic [8:0]       r_held;
  logic [CNT_W-1:0] r_count;

  ps2_scan2ascii u_scan2ascii (
    .i_code  (r_byte),
    .o_ascii (w_ascii)
  );

  assign w_key   = {w_ext, r_byte};
  assign w_match = r_key_down && (r_held == w_key);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_parse      <= StIdle;
      r_ev_valid   <= 1'b0;
      r_ev_code    <= 8'h00;
      r_ev_ext     <= 1'b0;
      r_ev_release <= 1'b0;
      r_ev_repeat  <= 1'b0;
      r_ev_ascii   <= 8'h00;
      r_key_down   <= 1'b0;
      r_held       <= 9'h000;
      r_count      <= '0;
      r_err        <= 1'b0;
    end else begin
      r_parse    <= w_parse_d;
      r_ev_valid <= w_emit;
      if (kbd_overflow) r_err <= 1'b1;
      if (w_emit) begin
        r_ev_code    <= r_byte;
        r_ev_ext     <= w_ext;
        r_ev_release <= w_rel;
        r_ev_repeat  <= !w_rel && w_match;
        r_ev_ascii   <= w_ext ? 8'h00 : w_ascii;
        if (!w_rel) begin
          if (!w_match) begin
            r_held     <= w_key;
            r_key_down <= 1'b1;
            r_count    <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
          end else if (COUNT_REPEAT) begin
            r_count    <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else if (w_key == r_held) begin
          r_key_down <= 1'b0;
          r_held     <= 9'h000;
        end
      end
    end
  end

  assign kbd_nextdata_n = r_pop_n;
  assign ev_valid       = r_ev_valid;
  assign ev_code        = r_ev_code;
  assign ev_ext         = r_ev_ext;
  assign ev_release     = r_ev_release;
  assign ev_repeat      = r_ev_repeat;
  assign ev_ascii       = r_ev_ascii;
  assign key_down       = r_key_down;
  assign held_code      = r_held;
  assign press_count    = r_count;
  assign err_overflow   = r_err;

endmodule

// File: tb/tb_ps2_key_event.sv
// Bench for ps2_key_event: a queue stands in for the keyboard FIFO, key events are
// generated at the event level, encoded to Set-2 bytes, and predicted by a small model.
module tb_ps2_key_event;

  localparam bit CountRepeat = 1'b0;

  logic       clock;
  logic       reset;
  logic       kbd_ready;
  logic [7:0] kbd_data;
  logic       kbd_overflow;
  logic       kbd_nextdata_n;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_release;
  logic       ev_repeat;
  logic [7:0] ev_ascii;
  logic       key_down;
  logic [8:0] held_code;
  logic [7:0] press_count;
  logic       err_overflow;

  ps2_key_event #(
    .CNT_W        (8),
    .COUNT_REPEAT (CountRepeat)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .kbd_ready      (kbd_ready),
    .kbd_data       (kbd_data),
    .kbd_overflow   (kbd_overflow),
    .kbd_nextdata_n (kbd_nextdata_n),
    .ev_valid       (ev_valid),
    .ev_code        (ev_code),
    .ev_ext         (ev_ext),
    .ev_release     (ev_release),
    .ev_repeat      (ev_repeat),
    .ev_ascii       (ev_ascii),
    .key_down       (key_down),
    .held_code      (held_code),
    .press_count    (press_count),
    .err_overflow   (err_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic       rpt;
    logic [7:0] ascii;
    logic       down;
    logic [8:0] held;
    logic [7:0] cnt;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] fifo[$];
  logic       m_down;
  logic [8:0] m_held;
  logic [7:0] m_cnt;
  int         pops = 0;
  bit         redundant_ok = 0;

  localparam logic [7:0] SCAN_TAB [36] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A,
    8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  function automatic logic [7:0] ref_ascii(input logic ext, input logic [7:0] code);
    if (ext) return 8'h00;
    if (code == 8'h29) return 8'h20;
    if (code == 8'h5A) return 8'h0D;
    for (int i = 0; i < 36; i++)
      if (SCAN_TAB[i] == code) return (i < 26) ? 8'(8'h61 + i) : 8'(8'h30 + i - 26);
    return 8'h00;
  endfunction

  task automatic exp_event(input logic ext, input logic [7:0] code, input logic rel);
    ev_t        e;
    logic [8:0] key;
    key     = {ext, code};
    e.code  = code;
    e.ext   = ext;
    e.rel   = rel;
    e.ascii = ref_ascii(ext, code);
    e.rpt   = 1'b0;
    if (!rel) begin
      if (m_down && m_held == key) begin
        e.rpt = 1'b1;
        if (CountRepeat) m_cnt++;
      end else begin
        m_down = 1'b1;
        m_held = key;
        m_cnt++;
      end
    end else if (m_held == key) begin
      m_down = 1'b0;
      m_held = 9'h000;
    end
    e.down = m_down;
    e.held = m_held;
    e.cnt  = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic send_event(input logic ext, input logic [7:0] code, input logic rel);
    if (ext) begin
      if (redundant_ok && $urandom_range(0, 5) == 0) fifo.push_back(8'hE0);
      fifo.push_back(8'hE0);
    end
    if (rel) fifo.push_back(8'hF0);
    fifo.push_back(code);
    exp_event(ext, code, rel);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (fifo.size() != 0 && n < 5000) begin
      @(negedge clock);
      n++;
    end
    check_eq("drain_bound", 32'(n < 5000), 32'd1);
    repeat (6) @(negedge clock);
  endtask

  task automatic do_reset();
    check_eq("exp_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset  = 1'b0;
    m_down = 1'b0;
    m_held = 9'h000;
    m_cnt  = 8'h00;
  endtask

  // ---------------- keyboard FIFO stand-in ----------------
  initial begin
    kbd_ready = 1'b0;
    kbd_data  = 8'h00;
    forever begin
      @(negedge clock);
      if (!kbd_nextdata_n) begin
        check_eq("pop_nonempty", 32'(fifo.size() != 0), 32'd1);
        if (fifo.size() != 0) void'(fifo.pop_front());
        pops++;
      end
      kbd_ready = (fifo.size() != 0);
      kbd_data  = kbd_ready ? fifo[0] : 8'h00;
    end
  end

  // ---------------- output monitor ----------------
  initial begin
    logic prev_low = 1'b0;
    bit   seen     = 0;
    int   gap      = 0;
    ev_t  e;
    forever begin
      @(negedge clock);
      if (!kbd_nextdata_n) begin
        check_eq("strobe_width", 32'(prev_low), 32'd0);
        if (seen) check_eq("strobe_gap", 32'(gap >= 2), 32'd1);
        seen = 1;
        gap  = 0;
      end else begin
        gap++;
      end
      if (ev_valid) begin
        check_eq("ev_timing", 32'(prev_low), 32'd1);
        if (exp_q.size() == 0) begin
          check_eq("spurious_ev", 32'(ev_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("ev_code", 32'(ev_code), 32'(e.code));
          check_eq("ev_ext", 32'(ev_ext), 32'(e.ext));
          check_eq("ev_release", 32'(ev_release), 32'(e.rel));
          check_eq("ev_repeat", 32'(ev_repeat), 32'(e.rpt));
          check_eq("ev_ascii", 32'(ev_ascii), 32'(e.ascii));
          check_eq("key_down", 32'(key_down), 32'(e.down));
          check_eq("held_code", 32'(held_code), 32'(e.held));
          check_eq("press_count", 32'(press_count), 32'(e.cnt));
        end
      end
      prev_low = !kbd_nextdata_n;
    end
  end

  initial begin
    #900000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  localparam logic [7:0] POOL [8] = '{8'h1C, 8'h32, 8'h21, 8'h29, 8'h45, 8'h5A, 8'h74, 8'h6B};

  initial begin
    int p0;
    int r;
    reset        = 1'b1;
    kbd_overflow = 1'b0;
    m_down       = 1'b0;
    m_held       = 9'h000;
    m_cnt        = 8'h00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_eq("rst_nextdata_n", 32'(kbd_nextdata_n), 32'd1);
    check_eq("rst_ev_valid", 32'(ev_valid), 32'd0);
    check_eq("rst_ev_code", 32'(ev_code), 32'd0);
    check_eq("rst_ev_ascii", 32'(ev_ascii), 32'd0);
    check_eq("rst_key_down", 32'(key_down), 32'd0);
    check_eq("rst_held", 32'(held_code), 32'd0);
    check_eq("rst_count", 32'(press_count), 32'd0);
    check_eq("rst_err", 32'(err_overflow), 32'd0);

    // make then break of 'a'
    send_event(1'b0, 8'h1C, 1'b0);
    wait_idle();
    check_eq("a_code", 32'(ev_code), 32'h1C);
    check_eq("a_ascii", 32'(ev_ascii), 32'h61);
    check_eq("a_count", 32'(press_count), 32'd1);
    check_eq("a_down", 32'(key_down), 32'd1);
    send_event(1'b0, 8'h1C, 1'b1);
    wait_idle();
    check_eq("a_rel", 32'(ev_release), 32'd1);
    check_eq("a_up", 32'(key_down), 32'd0);
    check_eq("a_count2", 32'(press_count), 32'd1);

    // typematic repeats do not count
    do_reset();
    for (int i = 0; i < 3; i++) send_event(1'b0, 8'h1B, 1'b0);
    send_event(1'b0, 8'h1B, 1'b1);
    wait_idle();
    check_eq("rep_count", 32'(press_count), 32'd1);
    check_eq("rep_down", 32'(key_down), 32'd0);

    // extended key
    send_event(1'b1, 8'h75, 1'b0);
    wait_idle();
    check_eq("ext_flag", 32'(ev_ext), 32'd1);
    check_eq("ext_ascii", 32'(ev_ascii), 32'd0);
    check_eq("ext_held", 32'(held_code), 32'h175);
    send_event(1'b1, 8'h75, 1'b1);
    wait_idle();
    check_eq("ext_cleared", 32'(held_code), 32'h000);

    // four bytes queued back to back
    p0 = pops;
    send_event(1'b0, 8'h16, 1'b0);
    send_event(1'b0, 8'h1E, 1'b0);
    send_event(1'b0, 8'h26, 1'b0);
    send_event(1'b0, 8'h25, 1'b0);
    wait_idle();
    check_eq("four_pops", 32'(pops - p0), 32'd4);

    // malformed F0 E0 75 restarts as extended make; E0 F0 F0 75 is an extended break
    fifo.push_back(8'hF0);
    fifo.push_back(8'hE0);
    fifo.push_back(8'h75);
    exp_event(1'b1, 8'h75, 1'b0);
    fifo.push_back(8'hE0);
    fifo.push_back(8'hF0);
    fifo.push_back(8'hF0);
    fifo.push_back(8'h75);
    exp_event(1'b1, 8'h75, 1'b1);
    wait_idle();
    check_eq("malformed_held", 32'(held_code), 32'h000);

    // 256 non-repeat makes wrap the counter; AA/FA produce nothing
    do_reset();
    for (int i = 0; i < 256; i++) begin
      if (i % 16 == 0) fifo.push_back(8'hAA);
      if (i % 16 == 8) fifo.push_back(8'hFA);
      send_event(1'b0, (i % 2 == 1) ? 8'h32 : 8'h1C, 1'b0);
    end
    wait_idle();
    check_eq("wrap_count", 32'(press_count), 32'd0);
    check_eq("wrap_held", 32'(held_code), 32'h032);

    // reset discards a partial E0 F0 prefix
    fifo.push_back(8'hE0);
    fifo.push_back(8'hF0);
    wait_idle();
    do_reset();
    send_event(1'b0, 8'h1C, 1'b0);
    wait_idle();
    check_eq("rst_seq_ext", 32'(ev_ext), 32'd0);
    check_eq("rst_seq_rel", 32'(ev_release), 32'd0);
    check_eq("rst_seq_held", 32'(held_code), 32'h01C);

    // overflow is sticky until reset
    @(negedge clock);
    kbd_overflow = 1'b1;
    @(negedge clock);
    kbd_overflow = 1'b0;
    repeat (10) @(negedge clock);
    check_eq("ovf_sticky", 32'(err_overflow), 32'd1);
    do_reset();
    @(negedge clock);
    check_eq("ovf_cleared", 32'(err_overflow), 32'd0);

    // randomized event stream
    redundant_ok = 1;
    for (int n = 0; n < 250; n++) begin
      r = int'($urandom_range(0, 9));
      if (m_down && r < 4) begin
        send_event(m_held[8], m_held[7:0], 1'b1);
      end else if (m_down && r < 6) begin
        send_event(m_held[8], m_held[7:0], 1'b0);
      end else begin
        send_event(1'($urandom_range(0, 1)), POOL[$urandom_range(0, 7)],
                   ($urandom_range(0, 3) == 0));
      end
      if ($urandom_range(0, 7) == 0) fifo.push_back(($urandom_range(0, 1) == 1) ? 8'hAA : 8'hFA);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clock);
    end
    wait_idle();
    check_eq("rand_count", 32'(press_count), 32'(m_cnt));
    check_eq("exp_left", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
